// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// A shared prescaler produces a base tick. Each channel runs OFF, ON, BLINK or BURST,
// programmed through a one-clock write port, and all channels can be phase-aligned by i_Sync.
// Ports:
//   i_Clk, i_Rst_L      clock, asynchronous active-low reset
//   i_Wr_DV             write strobe; loads i_Wr_Mode/i_Wr_Half/i_Wr_Burst into channel i_Wr_Ch
//   i_Sync              restart every channel at the start of its ON phase, prescaler to 0
//   o_LED               registered LED drive, bit n = channel n
//   o_Tick              high for one clock per base tick
//   o_Burst_Done        registered one-clock pulse when a BURST channel enters its gap
`timescale 1ns/1ps
module led_pattern_gen #(
   parameter int NUM_CH        = 4,
   parameter int CLKS_PER_TICK = 25000,
   parameter int PERIOD_W      = 12,
   parameter int BURST_W       = 4,
   parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Wr_DV,
   input  logic [CH_W-1:0]     i_Wr_Ch,
   input  logic [1:0]          i_Wr_Mode,
   input  logic [PERIOD_W-1:0] i_Wr_Half,
   input  logic [BURST_W-1:0]  i_Wr_Burst,
   input  logic                i_Sync,
   output logic [NUM_CH-1:0]   o_LED,
   output logic                o_Tick,
   output logic [NUM_CH-1:0]   o_Burst_Done
);

   localparam int PRE_W = $clog2(CLKS_PER_TICK);
   // Two extra bits so the gap length 4*half-1 fits even at the largest half-period.
   localparam int CNT_W = PERIOD_W + 2;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_TICK - 1);

   typedef enum logic [1:0] {ModeOff = 2'd0, ModeOn, ModeBlink, ModeBurst} mode_e;
   typedef enum logic [1:0] {StOnPh, StOffPh, StGap} state_e;

   logic [PRE_W-1:0]    r_pre;
   logic                w_tick;
   logic [PERIOD_W-1:0] w_wr_half;
   logic [BURST_W-1:0]  w_wr_burst;

   assign w_tick = (r_pre == PRE_MAX);
   assign o_Tick = w_tick;

   // Zero is not a usable length; store it as one.
   assign w_wr_half  = (i_Wr_Half == '0) ? PERIOD_W'(1) : i_Wr_Half;
   assign w_wr_burst = (i_Wr_Burst == '0) ? BURST_W'(1) : i_Wr_Burst;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_pre <= '0;
      end else if (i_Sync || w_tick) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      mode_e               r_mode,  w_mode_nxt;
      state_e              r_state, w_state_nxt;
      logic [PERIOD_W-1:0] r_half,  w_half_nxt;
      logic [BURST_W-1:0]  r_burst, w_burst_nxt;
      logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
      logic [BURST_W-1:0]  r_pcnt,  w_pcnt_nxt;
      logic                r_led,   w_led_nxt;
      logic                r_done,  w_done_nxt;
      logic                w_wr_hit;
      logic [CNT_W-1:0]    w_half_m1;
      logic [CNT_W-1:0]    w_gap_m1;
      logic [BURST_W-1:0]  w_burst_m1;

      // Out-of-range channel numbers match no channel, so such writes are dropped.
      assign w_wr_hit   = i_Wr_DV && (32'(i_Wr_Ch) == 32'(n));
      assign w_half_m1  = {2'b00, r_half} - CNT_W'(1);
      assign w_gap_m1   = {r_half, 2'b00} - CNT_W'(1);
      assign w_burst_m1 = r_burst - BURST_W'(1);

      // Priority: write, then sync, then tick; a colliding tick is not counted.
      always_comb begin
         w_mode_nxt  = r_mode;
         w_state_nxt = r_state;
         w_half_nxt  = r_half;
         w_burst_nxt = r_burst;
         w_cnt_nxt   = r_cnt;
         w_pcnt_nxt  = r_pcnt;
         w_led_nxt   = r_led;
         w_done_nxt  = 1'b0;
         if (w_wr_hit) begin
            w_mode_nxt  = mode_e'(i_Wr_Mode);
            w_half_nxt  = w_wr_half;
            w_burst_nxt = w_wr_burst;
            w_state_nxt = StOnPh;
            w_cnt_nxt   = '0;
            w_pcnt_nxt  = '0;
            w_led_nxt   = (mode_e'(i_Wr_Mode) != ModeOff);
         end else if (i_Sync) begin
            w_state_nxt = StOnPh;
            w_cnt_nxt   = '0;
            w_pcnt_nxt  = '0;
            if (r_mode == ModeBlink || r_mode == ModeBurst) begin
               w_led_nxt = 1'b1;
            end
         end else if (w_tick) begin
            unique case (r_mode)
               ModeOff: begin
                  w_cnt_nxt  = '0;
                  w_pcnt_nxt = '0;
                  w_led_nxt  = 1'b0;
               end
               ModeOn: begin
                  w_cnt_nxt  = '0;
                  w_pcnt_nxt = '0;
                  w_led_nxt  = 1'b1;
               end
               ModeBlink: begin
                  if (r_cnt == w_half_m1) begin
                     w_led_nxt = !r_led;
                     w_cnt_nxt = '0;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end
               ModeBurst: begin
                  unique case (r_state)
                     StOnPh: begin
                        if (r_cnt == w_half_m1) begin
                           w_cnt_nxt   = '0;
                           w_state_nxt = StOffPh;
                           w_led_nxt   = 1'b0;
                        end else begin
                           w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                     end
                     StOffPh: begin
                        if (r_cnt == w_half_m1) begin
                           w_cnt_nxt = '0;
                           if (r_pcnt == w_burst_m1) begin
                              w_state_nxt = StGap;
                              w_pcnt_nxt  = '0;
                              w_done_nxt  = 1'b1;
                           end else begin
                              w_pcnt_nxt  = r_pcnt + BURST_W'(1);
                              w_state_nxt = StOnPh;
                              w_led_nxt   = 1'b1;
                           end
                        end else begin
                           w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                     end
                     StGap: begin
                        if (r_cnt == w_gap_m1) begin
                           w_cnt_nxt   = '0;
                           w_state_nxt = StOnPh;
                           w_led_nxt   = 1'b1;
                        end else begin
                           w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                     end
                     default: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StOnPh;
                        w_led_nxt   = 1'b1;
                     end
                  endcase
               end
            endcase
         end
      end

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
         if (!i_Rst_L) begin
            r_mode  <= ModeOff;
            r_state <= StOnPh;
            r_half  <= PERIOD_W'(1);
            r_burst <= BURST_W'(1);
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            r_mode  <= w_mode_nxt;
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            r_burst <= w_burst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_led   <= w_led_nxt;
            r_done  <= w_done_nxt;
         end
      end

      assign o_LED[n]        = r_led;
      assign o_Burst_Done[n] = r_done;
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen.
// The stimulus process updates a tick-count model on every clock edge and queues the expected
// outputs; a monitor on the falling edge pops and compares against the DUT.
`timescale 1ns/1ps
module tb_led_pattern_gen;

   localparam int NCH = 3;
   localparam int CPT = 4;
   localparam int PW  = 4;
   localparam int BW  = 3;
   localparam int CHW = 2;

   logic           i_Clk;
   logic           i_Rst_L;
   logic           i_Wr_DV;
   logic [CHW-1:0] i_Wr_Ch;
   logic [1:0]     i_Wr_Mode;
   logic [PW-1:0]  i_Wr_Half;
   logic [BW-1:0]  i_Wr_Burst;
   logic           i_Sync;
   logic [NCH-1:0] o_LED;
   logic           o_Tick;
   logic [NCH-1:0] o_Burst_Done;

   led_pattern_gen #(
      .NUM_CH       (NCH),
      .CLKS_PER_TICK(CPT),
      .PERIOD_W     (PW),
      .BURST_W      (BW),
      .CH_W         (CHW)
   ) u_dut (
      .i_Clk       (i_Clk),
      .i_Rst_L     (i_Rst_L),
      .i_Wr_DV     (i_Wr_DV),
      .i_Wr_Ch     (i_Wr_Ch),
      .i_Wr_Mode   (i_Wr_Mode),
      .i_Wr_Half   (i_Wr_Half),
      .i_Wr_Burst  (i_Wr_Burst),
      .i_Sync      (i_Sync),
      .o_LED       (o_LED),
      .o_Tick      (o_Tick),
      .o_Burst_Done(o_Burst_Done)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   typedef struct packed {
      logic [NCH-1:0] led;
      logic [NCH-1:0] done;
      logic           tick;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model: per channel, the number of ticks elapsed since the pattern last restarted.
   int             m_p;
   int             m_mode [NCH];
   int             m_half [NCH];
   int             m_burst[NCH];
   int             m_t    [NCH];
   logic [NCH-1:0] m_done;

   function automatic void model_reset();
      m_p    = 0;
      m_done = '0;
      for (int n = 0; n < NCH; n++) begin
         m_mode[n]  = 0;
         m_half[n]  = 1;
         m_burst[n] = 1;
         m_t[n]     = 0;
      end
   endfunction

   function automatic int burst_on_len(int n);
      return 2 * m_half[n] * m_burst[n];
   endfunction

   function automatic int burst_period(int n);
      return burst_on_len(n) + 4 * m_half[n];
   endfunction

   function automatic logic led_of(int n);
      int pos;
      case (m_mode[n])
         0: return 1'b0;
         1: return 1'b1;
         2: return ((m_t[n] / m_half[n]) % 2) == 0;
         default: begin
            pos = m_t[n] % burst_period(n);
            return (pos < burst_on_len(n)) && (((pos / m_half[n]) % 2) == 0);
         end
      endcase
   endfunction

   function automatic void model_edge(logic wr, int ch, int m, int h, int b, logic sync);
      logic tick;
      tick   = (m_p == CPT - 1);
      m_done = '0;
      for (int n = 0; n < NCH; n++) begin
         if (wr && ch == n) begin
            m_mode[n]  = m;
            m_half[n]  = (h == 0) ? 1 : h;
            m_burst[n] = (b == 0) ? 1 : b;
            m_t[n]     = 0;
         end else if (sync) begin
            m_t[n] = 0;
         end else if (tick && m_mode[n] >= 2) begin
            m_t[n]++;
            if (m_mode[n] == 3 && (m_t[n] % burst_period(n)) == burst_on_len(n)) begin
               m_done[n] = 1'b1;
            end
         end
      end
      m_p = (sync || tick) ? 0 : m_p + 1;
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      for (int n = 0; n < NCH; n++) e.led[n] = led_of(n);
      e.done = m_done;
      e.tick = (m_p == CPT - 1);
      return e;
   endfunction

   // Monitor: one expected entry is queued per rising edge and consumed on the next falling edge.
   always @(negedge i_Clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (o_LED !== e.led) begin
            errors++;
            $display("FAIL led @%0t: got %b want %b", $time, o_LED, e.led);
         end
         checks++;
         if (o_Burst_Done !== e.done) begin
            errors++;
            $display("FAIL burst_done @%0t: got %b want %b", $time, o_Burst_Done, e.done);
         end
         checks++;
         if (o_Tick !== e.tick) begin
            errors++;
            $display("FAIL tick @%0t: got %b want %b", $time, o_Tick, e.tick);
         end
      end
   end

   // Called 1 time unit after a rising edge; drives inputs for the next edge.
   task automatic step(input logic wr, input int ch, input int m, input int h, input int b,
                       input logic sync);
      i_Wr_DV    = wr;
      i_Wr_Ch    = CHW'(ch);
      i_Wr_Mode  = 2'(m);
      i_Wr_Half  = PW'(h);
      i_Wr_Burst = BW'(b);
      i_Sync     = sync;
      @(posedge i_Clk);
      model_edge(wr, ch, m, h, b, sync);
      exp_q.push_back(cur_exp());
      #1;
      i_Wr_DV = 1'b0;
      i_Sync  = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic wr(input int ch, input int m, input int h, input int b);
      step(1'b1, ch, m, h, b, 1'b0);
   endtask

   task automatic sync_pulse();
      step(1'b0, 0, 0, 0, 0, 1'b1);
   endtask

   // Asserts reset between edges; the entry already queued for this cycle becomes the reset state.
   task automatic apply_reset();
      i_Rst_L = 1'b0;
      model_reset();
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      exp_q.push_back(cur_exp());
      for (int i = 0; i < 3; i++) begin
         @(posedge i_Clk);
         exp_q.push_back(cur_exp());
         #1;
      end
      i_Rst_L = 1'b1;
   endtask

   initial begin
      int kind;
      i_Rst_L    = 1'b0;
      i_Wr_DV    = 1'b0;
      i_Wr_Ch    = '0;
      i_Wr_Mode  = '0;
      i_Wr_Half  = '0;
      i_Wr_Burst = '0;
      i_Sync     = 1'b0;
      model_reset();
      @(posedge i_Clk);
      #1;
      apply_reset();
      idle(6);

      // Reset mid-pattern while the LED is lit, then tick restart.
      wr(0, 2, 2, 0);
      idle(5);
      sync_pulse();
      idle(2);
      apply_reset();
      idle(8);

      // BLINK half=2: 8 on, 8 off.
      wr(0, 2, 2, 0);
      sync_pulse();
      idle(40);

      // BURST half=2 burst=2: 64-clock period with one done pulse.
      wr(1, 3, 2, 2);
      sync_pulse();
      idle(140);

      // Invalid channel is ignored; valid channel lights next cycle.
      wr(0, 0, 1, 1);
      wr(1, 0, 1, 1);
      idle(2);
      wr(3, 1, 1, 1);
      idle(3);
      wr(2, 1, 1, 1);
      idle(3);

      // Two BLINK channels out of phase, then realigned by sync.
      wr(0, 2, 3, 0);
      idle(7);
      wr(1, 2, 5, 0);
      idle(9);
      sync_pulse();
      idle(60);

      // Zero half/burst behave as one; then a write landing on a tick edge.
      wr(2, 3, 0, 0);
      idle(60);
      while (m_p != CPT - 1) idle(1);
      wr(2, 3, 2, 1);
      idle(40);

      // Largest half-period exercises the widest gap count.
      wr(0, 3, 15, 1);
      idle(400);

      // Write and sync on the same edge.
      step(1'b1, 1, 3, 1, 2, 1'b1);
      idle(50);

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 7) begin
            step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0));
         end else if (kind < 9) begin
            sync_pulse();
         end else begin
            while (m_p != CPT - 1) idle(1);
            wr(int'($urandom_range(0, 2)), int'($urandom_range(2, 3)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
         end
         idle(int'($urandom_range(0, 60)));
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge i_Clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED pattern generator driven from one system clock. A shared prescaler makes a base tick. Each channel is independently programmed through a simple write port to OFF, ON, BLINK or BURST mode, with a per-channel half-period and burst count. It is the general-purpose successor to the fixed-rate LED blinkers and sits at board top level between the UART/control logic and the LED pins.

Parameters:
NUM_CH, 4, number of LED channels (1..16)
CLKS_PER_TICK, 25000, clocks per base tick (1 ms at 25 MHz); minimum 2
PERIOD_W, 12, width of half-period field, in ticks
BURST_W, 4, width of burst-count field
CH_W, $clog2(NUM_CH) (min 1), width of channel select

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Wr_DV  in  1  write strobe, one clock
i_Wr_Ch  in  CH_W  target channel
i_Wr_Mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
i_Wr_Half  in  PERIOD_W  half-period in ticks
i_Wr_Burst  in  BURST_W  pulses per burst
i_Sync  in  1  one-clock pulse; phase-align all channels
o_LED  out  NUM_CH  LED drive, bit n = channel n
o_Tick  out  1  high one clock per base tick
o_Burst_Done  out  NUM_CH  one-clock pulse when channel enters GAP

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0; all modes OFF; half=1; burst=1.
  - Channel counters and states cleared.
  - o_LED=0, o_Burst_Done=0.
  - Assertion mid-pattern forces these values immediately.
- Prescaler:
  - Counts 0..CLKS_PER_TICK-1, then wraps.
  - tick = (prescaler==CLKS_PER_TICK-1); o_Tick = tick.
  - All channel state advances only on edges where tick=1.
- Write (edge with i_Wr_DV=1):
  - Loads mode, half and burst into channel i_Wr_Ch.
  - Clears that channel's tick counter and pulse counter; state -> ON_PH.
  - i_Wr_Ch >= NUM_CH: write ignored, no state change anywhere.
  - Half=0 is stored as 1; burst=0 is stored as 1.
  - The prescaler is not reset, so the first phase after a write may be short by up to one tick.
- o_LED after a write edge:
  - OFF: 0.
  - ON: 1.
  - BLINK/BURST: 1 (start of ON_PH).
- i_Sync edge:
  - prescaler -> 0.
  - Every channel: counters cleared, state -> ON_PH, modes and config kept.
  - BLINK/BURST LEDs -> 1; OFF/ON unchanged.
- Simultaneous events:
  - Write and sync together: both apply; the written channel takes the new config with synced phase.
  - Write and tick together: write wins for that channel; the tick is not counted.
- BLINK:
  - Per tick cnt++.
  - When cnt==half-1 on a tick: LED toggles, cnt->0.
  - Gives half ticks on, half ticks off.
- BURST states:
  - ON_PH (LED 1, half ticks) -> OFF_PH.
  - OFF_PH (LED 0, half ticks): at end, if pcnt==burst-1 -> GAP, pcnt->0, o_Burst_Done[n]=1 for that clock; else pcnt++ -> ON_PH.
  - GAP (LED 0, 4*half ticks) -> ON_PH.
  - GAP counter width is PERIOD_W+2, with no overflow at max half.
- OFF/ON: counters held at 0; o_Burst_Done never pulses.
- All outputs except o_Tick are registered, with no combinational path from inputs.
- Channels are fully independent; a write to one never disturbs another.

Test Plan:
1. CLKS_PER_TICK=4. Run a BLINK pattern, assert i_Rst_L low mid-pattern -> o_LED=0 same cycle. After release, o_Tick first high on the 4th clock.
2. Write ch0 BLINK half=2, then pulse i_Sync -> o_LED[0] is 1 for 8 clocks, then 0 for 8, repeating; o_Tick every 4 clocks.
3. Write ch1 BURST half=2 burst=2, then i_Sync -> o_LED[1] pattern 8 on, 8 off, 8 on, 8 off, 32 off, with period 64 clocks. o_Burst_Done[1] pulses once per period, on the clock after the second OFF_PH ends.
4. NUM_CH=3: write Ch=3 mode ON -> o_LED stays 3'b000. Write Ch=2 ON -> o_LED=3'b100 the next cycle.
5. Two channels in BLINK with half=3 and half=5 run out of phase; pulse i_Sync -> both LEDs 1 on the next cycle and both toggle at 12 and 20 clocks respectively.
6. Write half=0, burst=0 in BURST mode -> behaves as half=1, burst=1: 4 on, 4 off, 16 off, period 24 clocks. A write colliding with a tick -> channel restarts ON_PH with the full first phase.
